// File: rtl/vga_mem_arbiter.sv
// Single-port RAM arbiter: display reads have absolute priority, two writers share the rest round-robin.
// Optional: define VGA_ARB_BLANK_WR_EN to restrict writes to blanking intervals.
module vga_mem_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_valid,
    input  logic              wr0_req,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_gnt,
    input  logic              wr1_req,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_gnt,
    input  logic              blank,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              starve0,
    output logic              starve1
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        w_req;
    logic [1:0]        w_elig;
    logic [1:0]        w_sel;
    logic [1:0]        w_starve;
    logic [1:0]        r_gnt;
    logic              r_favour1;
    logic              w_blank_ok;
    logic [DATA_W-1:0] r_rdata_hold;

`ifdef VGA_ARB_BLANK_WR_EN
    assign w_blank_ok = blank;
`else
    logic w_unused_blank;
    assign w_unused_blank = blank;
    assign w_blank_ok     = 1'b1;
`endif

    assign w_req = {wr1_req, wr0_req};

    // A writer whose gnt is showing this cycle is excluded so its held request is not served twice.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_writer
            logic [CNT_W-1:0] r_wait;
            logic [CNT_W-1:0] w_wait_next;
            logic             r_starve;

            assign w_elig[gi]   = w_req[gi] & ~r_gnt[gi] & w_blank_ok;
            assign w_starve[gi] = r_starve;

            always_comb begin
                w_wait_next = r_wait;
                if (!w_req[gi] || r_gnt[gi])
                    w_wait_next = '0;
                else if (r_wait != CNT_W'(MAX_WAIT))
                    w_wait_next = r_wait + CNT_W'(1);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wait   <= '0;
                    r_starve <= 1'b0;
                end else begin
                    r_wait <= w_wait_next;
                    if (w_wait_next == CNT_W'(MAX_WAIT))
                        r_starve <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = IDLE;
        w_sel        = 2'b00;
        if (disp_req) begin
            w_state_next = RD;
        end else if (w_elig[0] && (!w_elig[1] || !r_favour1)) begin
            w_state_next = WR;
            w_sel        = 2'b01;
        end else if (w_elig[1]) begin
            w_state_next = WR;
            w_sel        = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            r_gnt        <= 2'b00;
            r_favour1    <= 1'b0;
            disp_valid   <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            mem_en     <= (w_state_next != IDLE);
            mem_we     <= (w_state_next == WR);
            r_gnt      <= w_sel;
            disp_valid <= (r_state == RD);
            if (w_state_next == RD)
                mem_addr <= disp_addr;
            if (w_sel[0]) begin
                mem_addr  <= wr0_addr;
                mem_wdata <= wr0_data;
                r_favour1 <= 1'b1;
            end
            if (w_sel[1]) begin
                mem_addr  <= wr1_addr;
                mem_wdata <= wr1_data;
                r_favour1 <= 1'b0;
            end
            if (disp_valid)
                r_rdata_hold <= mem_rdata;
        end
    end

    // Read data arrives from the RAM in the disp_valid cycle itself, so it is passed through then and held afterwards.
    assign disp_rdata = disp_valid ? mem_rdata : r_rdata_hold;
    assign wr0_gnt    = r_gnt[0];
    assign wr1_gnt    = r_gnt[1];
    assign starve0    = w_starve[0];
    assign starve1    = w_starve[1];

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a 1-cycle-latency RAM model; MAX_WAIT set to 4.
module tb_vga_mem_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_rdata;
    logic          disp_valid;
    logic          wr0_req = 1'b0;
    logic [AW-1:0] wr0_addr = '0;
    logic [DW-1:0] wr0_data = '0;
    logic          wr0_gnt;
    logic          wr1_req = 1'b0;
    logic [AW-1:0] wr1_addr = '0;
    logic [DW-1:0] wr1_data = '0;
    logic          wr1_gnt;
    logic          blank = 1'b0;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          starve0;
    logic          starve1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] ram [2**AW];

    vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_valid(disp_valid),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
        .blank(blank),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .starve0(starve0), .starve1(starve1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        disp_req = 1'b0; disp_addr = '0;
        wr0_req = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_req = 1'b0; wr1_addr = '0; wr1_data = '0;
        blank = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        disp_req = 1'b1; disp_addr = 11'h055;
        wr0_req = 1'b1; wr0_addr = 11'h066; wr0_data = 8'h77;
        tick();
        tick();
        n_cmp++; if ({mem_en, mem_we, wr0_gnt, wr1_gnt, disp_valid, starve0, starve1} !== 7'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 0000000", {mem_en, mem_we, wr0_gnt, wr1_gnt, disp_valid, starve0, starve1});
        end
        n_cmp++; if (mem_addr !== 11'h000 || mem_wdata !== 8'h00) begin
            n_bad++; $display("FAIL reset_mem_bus: got addr %h data %h expected 000/00", mem_addr, mem_wdata);
        end
        n_cmp++; if (disp_rdata !== 8'h00) begin
            n_bad++; $display("FAIL reset_rdata: got %h expected 00", disp_rdata);
        end
        $display("test_reset: outputs held while rst=1");
        do_reset();
    endtask

    task automatic test_disp_read();
        do_reset();
        wr0_req = 1'b1; wr0_addr = 11'h123; wr0_data = 8'h5A;
        tick();
        wr0_req = 1'b0;
        tick();
        // cycle 0 of the read
        disp_req = 1'b1; disp_addr = 11'h123;
        tick();
        disp_req = 1'b0;
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 11'h123) begin
            n_bad++; $display("FAIL read_issue: got en %b we %b addr %h expected 1 0 123", mem_en, mem_we, mem_addr);
        end
        n_cmp++; if (disp_valid !== 1'b0) begin
            n_bad++; $display("FAIL read_early_valid: got %b expected 0", disp_valid);
        end
        tick();
        n_cmp++; if (disp_valid !== 1'b1 || disp_rdata !== 8'h5A) begin
            n_bad++; $display("FAIL read_data: got valid %b data %h expected 1 5a", disp_valid, disp_rdata);
        end
        tick();
        n_cmp++; if (disp_valid !== 1'b0 || disp_rdata !== 8'h5A) begin
            n_bad++; $display("FAIL read_hold: got valid %b data %h expected 0 5a", disp_valid, disp_rdata);
        end
        $display("test_disp_read: read 0x123 -> %h", disp_rdata);
    endtask

    task automatic test_round_robin();
        do_reset();
        wr0_req = 1'b1; wr0_addr = 11'h010; wr0_data = 8'hAA;
        wr1_req = 1'b1; wr1_addr = 11'h020; wr1_data = 8'hBB;
        tick();
        n_cmp++; if (wr0_gnt !== 1'b1 || wr1_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 11'h010 || mem_wdata !== 8'hAA) begin
            n_bad++; $display("FAIL rr_first: got g0 %b g1 %b we %b %h@%h expected 1 0 1 aa@010", wr0_gnt, wr1_gnt, mem_we, mem_wdata, mem_addr);
        end
        wr0_req = 1'b0;
        tick();
        n_cmp++; if (wr0_gnt !== 1'b0 || wr1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'h020 || mem_wdata !== 8'hBB) begin
            n_bad++; $display("FAIL rr_second: got g0 %b g1 %b we %b %h@%h expected 0 1 1 bb@020", wr0_gnt, wr1_gnt, mem_we, mem_wdata, mem_addr);
        end
        wr1_req = 1'b0;
        tick();
        n_cmp++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || wr0_gnt !== 1'b0 || wr1_gnt !== 1'b0 || mem_addr !== 11'h020 || mem_wdata !== 8'hBB) begin
            n_bad++; $display("FAIL rr_idle: got en %b we %b g %b%b %h@%h expected 0 0 00 bb@020", mem_en, mem_we, wr0_gnt, wr1_gnt, mem_wdata, mem_addr);
        end
        n_cmp++; if (ram[11'h010] !== 8'hAA || ram[11'h020] !== 8'hBB) begin
            n_bad++; $display("FAIL rr_ram: got %h %h expected aa bb", ram[11'h010], ram[11'h020]);
        end
        $display("test_round_robin: wr0 then wr1 written");
    endtask

    task automatic test_simultaneous();
        int grants;
        grants = 0;
        do_reset();
        disp_req = 1'b1; disp_addr = 11'h044;
        wr0_req = 1'b1; wr0_addr = 11'h011; wr0_data = 8'h11;
        wr1_req = 1'b1; wr1_addr = 11'h022; wr1_data = 8'h22;
        tick();
        disp_req = 1'b0;
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 11'h044 || wr0_gnt !== 1'b0 || wr1_gnt !== 1'b0) begin
            n_bad++; $display("FAIL sim_read: got en %b we %b addr %h g %b%b expected 1 0 044 00", mem_en, mem_we, mem_addr, wr0_gnt, wr1_gnt);
        end
        tick();
        grants += int'(wr0_gnt) + int'(wr1_gnt);
        n_cmp++; if (wr0_gnt !== 1'b1 || wr1_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 11'h011) begin
            n_bad++; $display("FAIL sim_wr0: got g %b%b we %b addr %h expected g0 only, 1, 011", wr0_gnt, wr1_gnt, mem_we, mem_addr);
        end
        wr0_req = 1'b0;
        tick();
        grants += int'(wr0_gnt) + int'(wr1_gnt);
        n_cmp++; if (wr0_gnt !== 1'b0 || wr1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'h022) begin
            n_bad++; $display("FAIL sim_wr1: got g %b%b we %b addr %h expected g1 only, 1, 022", wr0_gnt, wr1_gnt, mem_we, mem_addr);
        end
        wr1_req = 1'b0;
        tick();
        grants += int'(wr0_gnt) + int'(wr1_gnt);
        tick();
        grants += int'(wr0_gnt) + int'(wr1_gnt);
        n_cmp++; if (grants != 2) begin
            n_bad++; $display("FAIL sim_grant_count: got %0d expected 2", grants);
        end
        $display("test_simultaneous: read, wr0, wr1 served");
    endtask

    task automatic test_starve();
        int early_gnt;
        early_gnt = 0;
        do_reset();
        disp_req = 1'b1; disp_addr = 11'h100;
        wr1_req = 1'b1; wr1_addr = 11'h030; wr1_data = 8'hCC;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) disp_req = 1'b0;
            early_gnt += int'(wr1_gnt) + int'(mem_we);
            n_cmp++; if (starve1 !== (k >= 4)) begin
                n_bad++; $display("FAIL starve_cycle%0d: got %b expected %b", k, starve1, (k >= 4));
            end
        end
        n_cmp++; if (early_gnt != 0) begin
            n_bad++; $display("FAIL starve_no_write: got %0d writes expected 0", early_gnt);
        end
        tick();
        n_cmp++; if (wr1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'h030 || mem_wdata !== 8'hCC) begin
            n_bad++; $display("FAIL starve_gnt: got g1 %b we %b %h@%h expected 1 1 cc@030", wr1_gnt, mem_we, mem_wdata, mem_addr);
        end
        wr1_req = 1'b0;
        tick();
        n_cmp++; if (starve1 !== 1'b1 || starve0 !== 1'b0) begin
            n_bad++; $display("FAIL starve_sticky: got s1 %b s0 %b expected 1 0", starve1, starve0);
        end
        $display("test_starve: wr1 granted after display burst, starve1=%b", starve1);
    endtask

    task automatic test_blank();
        do_reset();
        blank = 1'b0;
        wr0_req = 1'b1; wr0_addr = 11'h040; wr0_data = 8'h3C;
`ifdef VGA_ARB_BLANK_WR_EN
        begin
            int early;
            early = 0;
            for (int k = 1; k <= 10; k++) begin
                tick();
                early += int'(wr0_gnt) + int'(mem_en);
                if (k == 10) blank = 1'b1;
            end
            n_cmp++; if (early != 0) begin
                n_bad++; $display("FAIL blank_hold_off: got %0d grants expected 0", early);
            end
        end
`endif
        tick();
        n_cmp++; if (wr0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'h040) begin
            n_bad++; $display("FAIL blank_gnt: got g0 %b we %b addr %h expected 1 1 040", wr0_gnt, mem_we, mem_addr);
        end
        wr0_req = 1'b0;
        blank = 1'b0;
        tick();
        $display("test_blank: wr0 granted");
    endtask

    task automatic test_reset_midop();
        int spurious;
        spurious = 0;
        do_reset();
        disp_req = 1'b1; disp_addr = 11'h123;
        tick();
        disp_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({mem_en, mem_we, wr0_gnt, wr1_gnt, disp_valid, starve0, starve1} !== 7'b0 || mem_addr !== 11'h000 || disp_rdata !== 8'h00) begin
            n_bad++; $display("FAIL midrst_outputs: got %b addr %h rdata %h expected 0000000 000 00", {mem_en, mem_we, wr0_gnt, wr1_gnt, disp_valid, starve0, starve1}, mem_addr, disp_rdata);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            spurious += int'(disp_valid);
        end
        rst = 1'b0;
        wr0_req = 1'b1; wr0_addr = 11'h050; wr0_data = 8'h0F;
        wr1_req = 1'b1; wr1_addr = 11'h060; wr1_data = 8'hF0;
        tick();
        spurious += int'(disp_valid);
        n_cmp++; if (spurious != 0) begin
            n_bad++; $display("FAIL midrst_valid: got %0d pulses expected 0", spurious);
        end
        n_cmp++; if (wr0_gnt !== 1'b1 || wr1_gnt !== 1'b0 || mem_addr !== 11'h050 || mem_wdata !== 8'h0F) begin
            n_bad++; $display("FAIL midrst_first_gnt: got g %b%b %h@%h expected g0 only 0f@050", wr0_gnt, wr1_gnt, mem_wdata, mem_addr);
        end
        clear_inputs();
        tick();
        $display("test_reset_midop: read discarded, wr0 first after reset");
    endtask

    initial begin
        test_reset();
        test_disp_read();
        test_round_robin();
        test_simultaneous();
        test_starve();
        test_blank();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
